ramio_responder: RTL and testbench
==================================

Name: ramio_responder

Overview:
- Target end of the RAMIO interface that the rv32i core drives as initiator. Serves byte, half-word and word reads and writes from an on-chip byte-lane BRAM.
- Applies read sign extension. Splits misaligned accesses into two BRAM cycles.
- Exposes one memory-mapped LED register.
- Sits between the core and block RAM in the top level.

Parameters:
- RAM_DEPTH_WORDS, 2048: number of 32-bit words in the backing BRAM; power of two.
- ADDR_LED, 32'hFFFF_FFFF: byte address of the LED register.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low (already decided)
- enable  in  1  request valid; may be held high across cycles
- write_type  in  2  00 none, 01 byte, 10 half, 11 word
- read_type  in  3  000 none; [2]=sign-extend; [1:0] 01 byte, 10 half, 11 word
- address  in  32  byte address
- data_in  in  32  write data, right-aligned (byte in [7:0], half in [15:0])
- data_out  out  32  read result, extended to 32 bits
- data_out_ready  out  1  data_out valid for the request currently presented
- busy  out  1  responder cannot accept a request this cycle
- led  out  1  LED register bit

Behaviour:
- Reset (rst_n low at a clk edge):
  - state goes to IDLE; busy=0, data_out_ready=0, data_out=0, led=1.
  - A pending second half of a write is abandoned; the first half stays written.
  - BRAM contents are not cleared.
- Acceptance: on an edge where enable=1 and busy=0, unless state is DONE and the live request still matches the completed one.
  - At acceptance, capture address, types and data.
  - Precedence: write_type!=0 means write; else read_type!=0 means read; else no-op.
- Word index w = address[log2(RAM_DEPTH_WORDS)+1:2]; offset o = address[1:0]. Upper address bits alias, except at ADDR_LED.
- Misaligned: half with o=3, or word with o!=0. Second word index is (w+1) mod RAM_DEPTH_WORDS, which wraps to 0.
- Lane mapping is little-endian. Byte k of the operand goes to byte address address+k. Lanes past byte 3 go to word w+1.
- States:
  - IDLE → (aligned write) IDLE. BRAM written at the acceptance edge; busy stays 0.
  - IDLE → (misaligned write) WR2. First lanes written at acceptance; WR2 writes the remaining lanes at the next edge and returns to IDLE. busy=1 during WR2.
  - IDLE → (aligned read) DONE. BRAM read registered at the acceptance edge.
  - IDLE → (misaligned read) RD2 → DONE. RD2 latches the first word's lanes and reads w+1; busy=1 in RD2.
  - DONE → IDLE on the first edge where enable=0 or the live address/read_type differs from the captured values.
- data_out_ready = (state==DONE) && enable && live address==captured && live read_type==captured. Combinational compare against live inputs, so a changed request never sees a stale ready.
- Read latency: ready in the cycle after acceptance when aligned; one cycle later when misaligned.
- Extension:
  - Byte/half are sign-extended if read_type[2]=1, else zero-extended.
  - Word ignores read_type[2].
- LED register:
  - Any write to ADDR_LED sets led=data_in[0] at the acceptance edge; no BRAM write.
  - A read of ADDR_LED returns {31'b0,led} with aligned timing.
  - Accesses to ADDR_LED are never treated as misaligned.
- Holding enable with an identical write re-executes it. This is idempotent; busy still follows the rules above.
- No-op request: consumes one acceptance, no state change.

Decomposition:
- Package ramio_pkg:
  - write_type/read_type encoding constants and typedefs.
  - state enum (IDLE, WR2, RD2, DONE).
  - ADDR_LED default.
  - lane-mask helper function (offset, size → 8-bit mask over two words).
- Sub-module ramio_bram: single-port, 4 byte lanes, per-lane write enables, 1-cycle registered read, no reset.

Test Plan:
- Word write 0x0←0xDEADBEEF, then word read 0x0 (read_type 3'b111) → data_out=0xDEADBEEF with data_out_ready 1 cycle after acceptance; busy never high.
- After the above:
  - read_type 3'b101 @0x3 → 0xFFFFFFDE.
  - 3'b001 @0x3 → 0x000000DE.
  - 3'b110 @0x2 → 0xFFFFDEAD.
  - 3'b010 @0x2 → 0x0000DEAD.
- Misaligned word write @0x2 of 0x11223344 → busy high exactly one cycle.
  - Word read @0x0 → 0x3344BEEF.
  - Half read 3'b010 @0x4 → 0x00001122.
  - Word read @0x2 → 0x11223344 with ready 2 cycles after acceptance.
- Wrap: half write 0xAABB @ RAM_DEPTH_WORDS*4-1 → top byte=0xBB, word 0 byte 0=0xAA; half read there → 0x0000AABB.
- Stale ready: hold enable on read @0x0 until ready, then change address to 0x4 with enable held → data_out_ready=0 that cycle; the next ready shows word 1.
- LED and reset:
  - Byte write 0x00 to ADDR_LED → led=0 next cycle; read returns 0x00000000.
  - Assert rst_n=0 during WR2 → after the edge busy=0, ready=0, led=1.

Source files
------------

// File: rtl/ramio_pkg.sv
// ramio_pkg: shared encodings for the RAMIO target.
//   - write_type / read_type encodings and the access size typedef
//   - responder state enum
//   - default LED register address
//   - lane_mask / spans_two_words helpers used for lane steering
package ramio_pkg;

  localparam logic [1:0] WT_NONE     = 2'b00;
  localparam logic [2:0] RT_NONE     = 3'b000;
  localparam int         RT_SIGN_BIT = 2;

  // Size field shared by write_type and read_type[1:0].
  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_WORD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR2  = 2'd1,
    RD2  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] ADDR_LED_DEFAULT = 32'hFFFF_FFFF;

  // Byte-lane mask over two consecutive words: bits [3:0] are the lanes of
  // word w, bits [7:4] the lanes of word w+1.
  function automatic logic [7:0] lane_mask(input logic [1:0] offset,
                                           input logic [1:0] size);
    logic [7:0] base;
    case (size)
      SZ_BYTE: base = 8'h01;
      SZ_HALF: base = 8'h03;
      SZ_WORD: base = 8'h0F;
      default: base = 8'h00;
    endcase
    return base << offset;
  endfunction

  // True when an access of this size at this offset touches word w+1.
  function automatic logic spans_two_words(input logic [1:0] offset,
                                           input logic [1:0] size);
    return (lane_mask(offset, size) >> 4) != 8'h00;
  endfunction

endpackage

// File: rtl/ramio_bram.sv
// ramio_bram: single-port byte-lane block RAM.
//   clk    in   clock
//   en     in   port enable; rdata only updates on enabled cycles
//   addr   in   word index
//   we     in   per-lane write enables (lane k = bits [8k+7:8k])
//   wdata  in   write data, already steered onto lanes
//   rdata  out  registered read data (read-before-write), held while en=0
// Contents are never reset.
module ramio_bram #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q_reg;

      always_ff @(posedge clk) begin
        if (en) begin
          if (we[gi]) begin
            mem[addr] <= wdata[8*gi +: 8];
          end
          q_reg <= mem[addr];
        end
      end

      assign rdata[8*gi +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/ramio_responder.sv
// ramio_responder: target end of the RAMIO bus, backed by a byte-lane BRAM.
//   clk, rst_n        clock, synchronous active-low reset
//   enable            request valid (may be held)
//   write_type        00 none, 01 byte, 10 half, 11 word
//   read_type         [2] sign-extend, [1:0] size as write_type
//   address, data_in  byte address, right-aligned write data
//   data_out          extended read result
//   data_out_ready    data_out belongs to the request currently presented
//   busy              no request can be accepted this cycle
//   led               memory-mapped LED bit at ADDR_LED
// Accesses crossing a word boundary take a second BRAM cycle (WR2 / RD2).
module ramio_responder
  import ramio_pkg::*;
#(
  parameter int          RAM_DEPTH_WORDS = 2048,
  parameter logic [31:0] ADDR_LED        = ADDR_LED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  write_type,
  input  logic [2:0]  read_type,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_out_ready,
  output logic        busy,
  output logic        led
);

  localparam int AW = $clog2(RAM_DEPTH_WORDS);

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] first_reg;
  logic [1:0]  wtype_reg;
  logic [2:0]  rtype_reg;
  logic        led_reg;

  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  // Live-request decode.
  logic       live_is_led, live_write, live_read, live_split;
  logic [1:0] live_size;
  logic [4:0] live_shamt;
  assign live_is_led = (address == ADDR_LED);
  assign live_write  = (write_type != WT_NONE);
  assign live_read   = !live_write && (read_type != RT_NONE);
  assign live_size   = live_write ? write_type : read_type[1:0];
  assign live_split  = !live_is_led && spans_two_words(address[1:0], live_size);
  assign live_shamt  = {address[1:0], 3'b000};

  // Captured-request decode.
  logic       cap_is_led, cap_rd_split;
  logic [4:0] cap_shamt;
  assign cap_is_led   = (addr_reg == ADDR_LED);
  assign cap_rd_split = !cap_is_led && spans_two_words(addr_reg[1:0], rtype_reg[1:0]);
  assign cap_shamt    = {addr_reg[1:0], 3'b000};

  logic busy_int, req_match, accept;
  assign busy_int  = (state_reg == WR2) || (state_reg == RD2);
  assign req_match = (address == addr_reg) && (read_type == rtype_reg);
  // A completed read that is still being presented is not re-accepted;
  // gating with rst_n keeps a reset edge from touching the BRAM.
  assign accept    = rst_n && enable && !busy_int && !((state_reg == DONE) && req_match);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (accept) begin
          if (live_write) begin
            state_next = live_split ? WR2 : IDLE;
          end else if (live_read) begin
            state_next = live_split ? RD2 : DONE;
          end else begin
            state_next = IDLE;
          end
        end else if ((state_reg == DONE) && !(enable && req_match)) begin
          state_next = IDLE;
        end
      end
      WR2:     state_next = IDLE;
      RD2:     state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, LED register and first-word latch for split reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
      wtype_reg <= WT_NONE;
      rtype_reg <= RT_NONE;
      first_reg <= 32'h0;
      led_reg   <= 1'b1;
    end else begin
      if (accept) begin
        addr_reg  <= address;
        wdata_reg <= data_in;
        wtype_reg <= write_type;
        rtype_reg <= read_type;
        if (live_write && live_is_led) begin
          led_reg <= data_in[0];
        end
      end
      if (state_reg == RD2) begin
        first_reg <= ram_rdata;
      end
    end
  end

  // Output logic: BRAM port steering and read-result extraction.
  logic [63:0] rd_pair;
  logic [31:0] rd_raw;
  logic [31:0] rd_result;
  always_comb begin
    ram_en    = accept;
    ram_addr  = address[AW+1:2];
    ram_we    = 4'b0000;
    ram_wdata = data_in << live_shamt;
    if (accept && live_write && !live_is_led) begin
      ram_we = 4'(lane_mask(address[1:0], write_type));
    end
    case (state_reg)
      WR2: begin
        // Remaining lanes land in the next word; index wraps naturally.
        ram_en    = rst_n;
        ram_addr  = addr_reg[AW+1:2] + 1'b1;
        ram_we    = rst_n ? 4'(lane_mask(addr_reg[1:0], wtype_reg) >> 4) : 4'b0000;
        ram_wdata = 32'(({32'h0, wdata_reg} << cap_shamt) >> 32);
      end
      RD2: begin
        ram_en   = rst_n;
        ram_addr = addr_reg[AW+1:2] + 1'b1;
      end
      default: ;
    endcase

    rd_pair = cap_rd_split ? {ram_rdata, first_reg} : {32'h0, ram_rdata};
    rd_raw  = 32'(rd_pair >> cap_shamt);
    case (rtype_reg[1:0])
      SZ_BYTE: rd_result = rtype_reg[RT_SIGN_BIT] ? {{24{rd_raw[7]}}, rd_raw[7:0]}
                                                  : {24'h0, rd_raw[7:0]};
      SZ_HALF: rd_result = rtype_reg[RT_SIGN_BIT] ? {{16{rd_raw[15]}}, rd_raw[15:0]}
                                                  : {16'h0, rd_raw[15:0]};
      default: rd_result = rd_raw;
    endcase
    if (cap_is_led) begin
      rd_result = {31'h0, led_reg};
    end
    data_out = (state_reg == DONE) ? rd_result : 32'h0;
  end

  // Compared against the live request so a changed request never sees ready.
  assign data_out_ready = (state_reg == DONE) && enable && req_match;
  assign busy           = busy_int;
  assign led            = led_reg;

  ramio_bram #(
    .DEPTH(RAM_DEPTH_WORDS),
    .AW   (AW)
  ) u_bram (
    .clk  (clk),
    .en   (ram_en),
    .addr (ram_addr),
    .we   (ram_we),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_ramio_responder.sv
// Scoreboard bench for ramio_responder: reads push their expected result into
// a queue; a monitor pops and compares whenever data_out_ready is seen.
module tb_ramio_responder;

  localparam int          DEPTH    = 2048;
  localparam int          BAW      = $clog2(DEPTH) + 2;
  localparam int          BYTES    = DEPTH * 4;
  localparam logic [31:0] LED_ADDR = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  write_type = 2'b00;
  logic [2:0]  read_type = 3'b000;
  logic [31:0] address = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        busy;
  logic        led;

  always #5 clk = ~clk;

  ramio_responder #(
    .RAM_DEPTH_WORDS(DEPTH),
    .ADDR_LED       (LED_ADDR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .write_type    (write_type),
    .read_type     (read_type),
    .address       (address),
    .data_in       (data_in),
    .data_out      (data_out),
    .data_out_ready(data_out_ready),
    .busy          (busy),
    .led           (led)
  );

  // Reference model: flat byte memory plus the LED bit.
  logic [7:0]  ref_mem [BYTES];
  logic        ref_led = 1'b1;
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;

  function automatic int size_bytes(input logic [1:0] s);
    return (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : (s == 2'd3) ? 4 : 0;
  endfunction

  function automatic logic [BAW-1:0] bidx(input logic [31:0] a, input int k);
    return a[BAW-1:0] + BAW'(k);
  endfunction

  function automatic bit is_split(input logic [31:0] a, input logic [1:0] s);
    return (a != LED_ADDR) && ((int'(a[1:0]) + size_bytes(s)) > 4);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [2:0] rt);
    logic [31:0] v;
    int n;
    if (a == LED_ADDR) return {31'h0, ref_led};
    n = size_bytes(rt[1:0]);
    v = 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[bidx(a, k)];
    if (rt[2] && n < 4 && v[8*n-1]) begin
      for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
    end
    return v;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [1:0] wt,
                           input logic [31:0] d, input int nmax);
    int n;
    if (a == LED_ADDR) begin
      ref_led = d[0];
    end else begin
      n = size_bytes(wt);
      if (n > nmax) n = nmax;
      for (int k = 0; k < n; k++) ref_mem[bidx(a, k)] = d[8*k +: 8];
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: one comparison per presented ready.
  always @(negedge clk) begin
    if (rst_n && data_out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ready_without_request: got data %h expected no ready", data_out);
      end else begin
        check("read_data", data_out, exp_q.pop_front());
      end
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [1:0] wt,
                          input logic [31:0] d, input bit chk);
    bit split;
    @(posedge clk); #1;
    address = a; write_type = wt; read_type = 3'b000; data_in = d; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0; write_type = 2'b00;
    split = is_split(a, wt);
    ref_write(a, wt, d, 4);
    @(negedge clk);
    if (chk) begin
      $display("write addr=%h type=%0d data=%h split=%0d", a, wt, d, split);
      check("busy_after_write", {31'h0, busy}, {31'h0, split});
      check("led_after_write", {31'h0, led}, {31'h0, ref_led});
    end
    if (split) begin
      @(negedge clk);
      if (chk) check("busy_end_write", {31'h0, busy}, 32'h0);
    end
  endtask

  task automatic wait_ready(input int exp_lat, input string name);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 8) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      got = data_out_ready;
    end
    if (!got) begin
      void'(exp_q.pop_back());
      checks++;
      failures++;
      $display("FAIL %s: no data_out_ready within %0d cycles, required latency %0d", name, n, exp_lat);
    end else begin
      check(name, n, exp_lat);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] rt, input logic [31:0] exp);
    int lat;
    lat = is_split(a, rt[1:0]) ? 2 : 1;
    @(posedge clk); #1;
    address = a; read_type = rt; write_type = 2'b00; enable = 1'b1;
    exp_q.push_back(exp);
    $display("read  addr=%h type=%b expect=%h latency=%0d", a, rt, exp, lat);
    wait_ready(lat, "read_latency");
    @(posedge clk); #1;
    enable = 1'b0; read_type = 3'b000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0]  wt;
    logic [2:0]  rt;
    int          r, pick;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_ready", {31'h0, data_out_ready}, 32'h0);
    check("reset_data_out", data_out, 32'h0);
    check("reset_led", {31'h0, led}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Give every BRAM byte a known value.
    for (int w = 0; w < DEPTH; w++) do_write(32'(w * 4), 2'b11, $urandom, 1'b0);

    // Aligned word write/read and narrow extensions.
    do_write(32'h0, 2'b11, 32'hDEADBEEF, 1'b1);
    do_read(32'h0, 3'b111, 32'hDEADBEEF);
    do_read(32'h3, 3'b101, 32'hFFFFFFDE);
    do_read(32'h3, 3'b001, 32'h000000DE);
    do_read(32'h2, 3'b110, 32'hFFFFDEAD);
    do_read(32'h2, 3'b010, 32'h0000DEAD);

    // Misaligned word write and reads across the boundary.
    do_write(32'h2, 2'b11, 32'h11223344, 1'b1);
    do_read(32'h0, 3'b011, 32'h3344BEEF);
    do_read(32'h4, 3'b010, 32'h00001122);
    do_read(32'h2, 3'b011, 32'h11223344);

    // Wrap from the last word to word 0.
    do_write(32'(BYTES - 1), 2'b10, 32'h0000AABB, 1'b1);
    do_read(32'(BYTES - 1), 3'b001, 32'h000000BB);
    do_read(32'h0, 3'b001, 32'h000000AA);
    do_read(32'(BYTES - 1), 3'b010, 32'h0000AABB);

    // Stale ready: switch address while enable stays high.
    @(posedge clk); #1;
    address = 32'h0; read_type = 3'b011; enable = 1'b1;
    exp_q.push_back(ref_read(32'h0, 3'b011));
    wait_ready(1, "hold_latency");
    @(posedge clk); #1;
    address = 32'h4;
    exp_q.push_back(ref_read(32'h4, 3'b011));
    @(negedge clk);
    check("stale_ready", {31'h0, data_out_ready}, 32'h0);
    wait_ready(1, "switched_latency");
    @(posedge clk); #1;
    enable = 1'b0; read_type = 3'b000;

    // LED register.
    do_write(LED_ADDR, 2'b01, 32'h00000000, 1'b1);
    do_read(LED_ADDR, 3'b011, 32'h00000000);
    do_write(LED_ADDR, 2'b11, 32'h00000001, 1'b1);
    do_read(LED_ADDR, 3'b011, 32'h00000001);
    do_write(LED_ADDR, 2'b10, 32'h00000000, 1'b1);

    // Reset during WR2: only the first word's lane is kept.
    @(posedge clk); #1;
    address = 32'h13; write_type = 2'b11; data_in = 32'h55667788; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0; write_type = 2'b00; rst_n = 1'b0;
    ref_write(32'h13, 2'b11, 32'h55667788, 1);
    ref_led = 1'b1;
    @(negedge clk);
    check("busy_in_wr2", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_ready", {31'h0, data_out_ready}, 32'h0);
    check("rst_led", {31'h0, led}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_read(32'h10, 3'b011, ref_read(32'h10, 3'b011));
    do_read(32'h14, 3'b011, ref_read(32'h14, 3'b011));

    // Randomized mix against the reference model.
    for (int i = 0; i < 400; i++) begin
      r    = $urandom_range(0, 9);
      pick = $urandom_range(0, 9);
      if (pick < 6)      a = 32'($urandom_range(0, 63));
      else if (pick < 8) a = 32'(BYTES - 8 + $urandom_range(0, 7));
      else if (pick < 9) a = ($urandom << BAW) | 32'($urandom_range(0, 63));
      else               a = LED_ADDR;
      if (r < 4) begin
        wt = 2'($urandom_range(1, 3));
        d  = $urandom;
        do_write(a, wt, d, 1'b1);
      end else if (r < 9) begin
        rt = {1'($urandom_range(0, 1)), 2'($urandom_range(1, 3))};
        do_read(a, rt, ref_read(a, rt));
      end else begin
        @(posedge clk); #1;
        address = a; write_type = 2'b00; read_type = 3'b000; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        @(negedge clk);
        $display("noop  addr=%h", a);
        check("noop_busy", {31'h0, busy}, 32'h0);
        check("noop_ready", {31'h0, data_out_ready}, 32'h0);
      end
    end

    repeat (2) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
